// File: rtl/regfile_sb.sv
// Scoreboarded register file: two combinational read ports, one writeback port,
// per-register busy bits with WAW detection, and a post-reset clearing sweep.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            setb,
  input  logic [AW-1:0]   ab,
  output logic            err
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy_q;

  // Address names a real register that holds state (not hardwired zero, not past NREGS).
  function automatic logic usable(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS)) && !(ZERO_REG && (a == '0));
  endfunction

  logic w_ok, s_ok, err_hit;

  always_comb begin
    w_ok    = we3 && usable(a3);
    s_ok    = setb && usable(ab);
    err_hit = s_ok && busy_q[ab] && !(we3 && (a3 == ab));
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Sweep sequencing and sticky WAW flag.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (err_hit) err_d = 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  // Storage: sweep clears one entry per cycle; in RUN a busy-set overrides the write's clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        regs[idx_q]   <= '0;
        busy_q[idx_q] <= 1'b0;
      end else begin
        if (w_ok) begin
          regs[a3]   <= wd3;
          busy_q[a3] <= 1'b0;
        end
        if (s_ok) busy_q[ab] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if ((state_q == RUN) && usable(a1)) begin
      if (BYPASS && we3 && (a3 == a1)) begin
        rd1 = wd3;
      end else begin
        rd1   = regs[a1];
        busy1 = busy_q[a1];
      end
    end
  end

  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if ((state_q == RUN) && usable(a2)) begin
      if (BYPASS && we3 && (a3 == a2)) begin
        rd2 = wd3;
      end else begin
        rd2   = regs[a2];
        busy2 = busy_q[a2];
      end
    end
  end

  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: four configurations driven from shared stimulus and
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic        we3, setb;
  logic [4:0]  a1, a2, a3, ab;
  logic [63:0] wd3;

  int checks   = 0;
  int failures = 0;
  bit mvalid   = 1'b0;

  // Configs: 0 default, 1 no bypass, 2 XLEN64/NREGS16/no zero reg, 3 NREGS12.
  logic [63:0] drd1 [4];
  logic [63:0] drd2 [4];
  logic        db1 [4];
  logic        db2 [4];
  logic        drdy [4];
  logic        derr [4];

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_3, rd2_3;
  logic [63:0] rd1_2, rd2_2;

  regfile_sb u0 (.clk(clk), .reset(reset), .ready(drdy[0]), .a1(a1), .a2(a2),
    .rd1(rd1_0), .rd2(rd2_0), .busy1(db1[0]), .busy2(db2[0]), .we3(we3), .a3(a3),
    .wd3(wd3[31:0]), .setb(setb), .ab(ab), .err(derr[0]));

  regfile_sb #(.BYPASS(1'b0)) u1 (.clk(clk), .reset(reset), .ready(drdy[1]), .a1(a1), .a2(a2),
    .rd1(rd1_1), .rd2(rd2_1), .busy1(db1[1]), .busy2(db2[1]), .we3(we3), .a3(a3),
    .wd3(wd3[31:0]), .setb(setb), .ab(ab), .err(derr[1]));

  regfile_sb #(.XLEN(64), .NREGS(16), .ZERO_REG(1'b0)) u2 (.clk(clk), .reset(reset),
    .ready(drdy[2]), .a1(a1[3:0]), .a2(a2[3:0]), .rd1(rd1_2), .rd2(rd2_2),
    .busy1(db1[2]), .busy2(db2[2]), .we3(we3), .a3(a3[3:0]), .wd3(wd3),
    .setb(setb), .ab(ab[3:0]), .err(derr[2]));

  regfile_sb #(.NREGS(12)) u3 (.clk(clk), .reset(reset), .ready(drdy[3]), .a1(a1[3:0]),
    .a2(a2[3:0]), .rd1(rd1_3), .rd2(rd2_3), .busy1(db1[3]), .busy2(db2[3]), .we3(we3),
    .a3(a3[3:0]), .wd3(wd3[31:0]), .setb(setb), .ab(ab[3:0]), .err(derr[3]));

  assign drd1[0] = 64'(rd1_0);
  assign drd2[0] = 64'(rd2_0);
  assign drd1[1] = 64'(rd1_1);
  assign drd2[1] = 64'(rd2_1);
  assign drd1[2] = rd1_2;
  assign drd2[2] = rd2_2;
  assign drd1[3] = 64'(rd1_3);
  assign drd2[3] = 64'(rd2_3);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Configuration table.
  function automatic int nr(input int c);
    case (c) 2: return 16; 3: return 12; default: return 32; endcase
  endfunction
  function automatic bit zr(input int c);  return c != 2; endfunction
  function automatic bit by(input int c);  return c != 1; endfunction
  function automatic logic [63:0] msk(input int c);
    return (c == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic int tr(input int c, input logic [4:0] a);
    return (c >= 2) ? int'(a[3:0]) : int'(a);
  endfunction

  // Behavioural model: contents vanish at reset; the file is usable NREGS edges later.
  logic [63:0] mmem [4][32];
  bit          mbsy [4][32];
  bit          merr [4];
  bit          mrun [4];
  int          mcnt [4];

  function automatic bit ok(input int c, input int a);
    return (a < nr(c)) && !(zr(c) && a == 0);
  endfunction

  function automatic logic [63:0] exp_rd(input int c, input logic [4:0] a);
    int ta = tr(c, a);
    if (!mrun[c] || !ok(c, ta)) return 64'd0;
    if (by(c) && we3 && tr(c, a3) == ta) return wd3 & msk(c);
    return mmem[c][ta];
  endfunction

  function automatic logic exp_bz(input int c, input logic [4:0] a);
    int ta = tr(c, a);
    if (!mrun[c] || !ok(c, ta)) return 1'b0;
    if (by(c) && we3 && tr(c, a3) == ta) return 1'b0;
    return mbsy[c][ta];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 4; c++) begin
      if (reset) begin
        mrun[c] = 1'b0;
        mcnt[c] = 0;
        merr[c] = 1'b0;
        for (int i = 0; i < 32; i++) begin
          mmem[c][i] = 64'd0;
          mbsy[c][i] = 1'b0;
        end
      end else if (!mrun[c]) begin
        mcnt[c]++;
        if (mcnt[c] == nr(c)) mrun[c] = 1'b1;
      end else begin
        int w = tr(c, a3);
        int s = tr(c, ab);
        bit wok = we3 && ok(c, w);
        bit sok = setb && ok(c, s);
        if (sok && mbsy[c][s] && !(we3 && w == s)) merr[c] = 1'b1;
        if (wok) begin
          mmem[c][w] = wd3 & msk(c);
          mbsy[c][w] = 1'b0;
        end
        if (sok) mbsy[c][s] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("u%0d.ready", c), 64'(drdy[c]), 64'(mrun[c]));
        chk($sformatf("u%0d.err", c),   64'(derr[c]), 64'(merr[c]));
        chk($sformatf("u%0d.rd1", c),   drd1[c], exp_rd(c, a1));
        chk($sformatf("u%0d.rd2", c),   drd2[c], exp_rd(c, a2));
        chk($sformatf("u%0d.busy1", c), 64'(db1[c]), 64'(exp_bz(c, a1)));
        chk($sformatf("u%0d.busy2", c), 64'(db2[c]), 64'(exp_bz(c, a2)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    mvalid = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; setb = 1'b0; a1 = '0; a2 = '0; a3 = '0; ab = '0; wd3 = '0;
  endtask

  int rn [4];

  // Count edges after reset release until each instance reports ready (bounded).
  task automatic count_ready();
    for (int c = 0; c < 4; c++) rn[c] = 0;
    reset = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      for (int c = 0; c < 4; c++)
        if (drdy[c] === 1'b1 && rn[c] == 0) rn[c] = n;
    end
    chk("ready_edges_u0", 64'(rn[0]), 64'd32);
    chk("ready_edges_u1", 64'(rn[1]), 64'd32);
    chk("ready_edges_u2", 64'(rn[2]), 64'd16);
    chk("ready_edges_u3", 64'(rn[3]), 64'd12);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    tick(); tick();
    chk("reset_ready", 64'(drdy[0]), 64'd0);
    chk("reset_err",   64'(derr[0]), 64'd0);
    count_ready();

    // Preload every register with a marker and mark it busy.
    for (int i = 0; i < 32; i++) begin
      we3 = 1'b1; a3 = 5'(i); wd3 = 64'hDEAD_BEEF_DEAD_BEEF;
      setb = 1'b1; ab = 5'(i); a1 = 5'(i);
      tick();
    end
    idle();
    reset = 1'b1;
    tick(); tick();
    count_ready();
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i); a2 = 5'(31 - i);
      #1;
      chk("swept_rd1", drd1[0], 64'd0);
      chk("swept_busy1", 64'(db1[0]), 64'd0);
      tick();
    end

    // Basic write/read and register 0.
    idle(); we3 = 1'b1; a3 = 5'd5; wd3 = 64'h0000_00AA;
    tick();
    idle(); a1 = 5'd5; #1;
    chk("basic_rd1", drd1[0], 64'h0000_00AA);
    we3 = 1'b1; a3 = 5'd0; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle(); a1 = 5'd0; #1;
    chk("zero_rd1_u0", drd1[0], 64'd0);
    chk("zero_rd1_u2", drd1[2], 64'hFFFF_FFFF_FFFF_FFFF);

    // Bypass vs no bypass.
    idle(); we3 = 1'b1; a3 = 5'd7; wd3 = 64'h1234_5678; a2 = 5'd7; #1;
    chk("bypass_rd2_u0", drd2[0], 64'h1234_5678);
    chk("nobypass_rd2_u1", drd2[1], 64'd0);
    tick();
    idle(); a2 = 5'd7; #1;
    chk("nobypass_late_u1", drd2[1], 64'h1234_5678);

    // Scoreboard set / clear / set-wins.
    idle(); setb = 1'b1; ab = 5'd3;
    tick();
    idle(); a1 = 5'd3; #1;
    chk("busy_set", 64'(db1[0]), 64'd1);
    we3 = 1'b1; a3 = 5'd3; wd3 = 64'h33; #1;
    chk("busy_bypass_clr", 64'(db1[0]), 64'd0);
    chk("busy_nobypass_old", 64'(db1[1]), 64'd1);
    tick();
    idle(); a1 = 5'd3; #1;
    chk("busy_cleared", 64'(db1[0]), 64'd0);
    setb = 1'b1; ab = 5'd3; we3 = 1'b1; a3 = 5'd3; wd3 = 64'h44;
    tick();
    idle(); a1 = 5'd3; #1;
    chk("set_wins_busy", 64'(db1[0]), 64'd1);
    chk("set_wins_rd1", drd1[0], 64'h44);
    chk("set_wins_err", 64'(derr[0]), 64'd0);

    // Register 0 busy-set: dropped with ZERO_REG, honoured without.
    idle(); setb = 1'b1; ab = 5'd0;
    tick();
    idle(); a1 = 5'd0; #1;
    chk("zero_busy_u0", 64'(db1[0]), 64'd0);
    chk("zero_busy_u2", 64'(db1[2]), 64'd1);

    // WAW: two issues to the same register with no writeback.
    idle(); setb = 1'b1; ab = 5'd4;
    tick();
    chk("waw_first", 64'(derr[0]), 64'd0);
    tick();
    idle(); #1;
    chk("waw_err", 64'(derr[0]), 64'd1);
    tick(); tick(); tick();
    chk("waw_sticky", 64'(derr[0]), 64'd1);

    // Reset mid-sweep restarts the count.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    chk("reset_clears_err", 64'(derr[0]), 64'd0);
    count_ready();

    // Out-of-range addresses on the 12-entry instance.
    idle(); we3 = 1'b1; a3 = 5'd13; wd3 = 64'h55; setb = 1'b1; ab = 5'd14;
    tick();
    idle(); setb = 1'b1; ab = 5'd14; a1 = 5'd13;
    tick();
    idle(); a1 = 5'd13; a2 = 5'd14; #1;
    chk("oor_rd1_u3", drd1[3], 64'd0);
    chk("oor_busy2_u3", 64'(db2[3]), 64'd0);
    chk("oor_err_u3", 64'(derr[3]), 64'd0);
    chk("inrange_err_u0", 64'(derr[0]), 64'd1);
    chk("inrange_rd1_u0", drd1[0], 64'h55);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
